frame_ram_arbiter: RTL and testbench

Shares the single-port frame RAM (one bit per cell, 24-bit address) between three masters: the display scanner (read-only), the SD-card pattern loader (write-mostly) and the life update engine (read/write). The display always wins. The loader and the engine alternate in bounded bursts, so a file load cannot starve the engine and the engine cannot starve a load. The block sits between the three masters and the RAM macro; it is the only driver of the RAM's address, data, rden and wren.

---
 rtl/frame_ram_arbiter_pkg.sv | 26 ++
 rtl/frame_ram_arbiter_if.sv | 54 +++++
 rtl/frame_ram_arbiter_rd_tag_pipe.sv | 36 +++
 rtl/frame_ram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_frame_ram_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// frame_ram_pkg
// Shared types and default widths for the frame RAM arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package frame_ram_pkg;

    localparam int c_ADDR_W     = 24;
    localparam int c_DATA_W     = 1;
    localparam int c_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_DISP = 2'd1,
        REQ_LD   = 2'd2,
        REQ_ENG  = 2'd3
    } req_tag_e;

    typedef enum logic {
        OWN_LD  = 1'b0,
        OWN_ENG = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/frame_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// frame_ram_arbiter_if
// Request/return bundle for the display, loader and engine masters.
// Revision: 1.0 - initial release
// ============================================================================
interface frame_ram_arbiter_if
    import frame_ram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
);
    logic              disp_valid;
    logic              disp_ready;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              ld_valid;
    logic              ld_ready;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              eng_valid;
    logic              eng_ready;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_rvalid;
    logic [DATA_W-1:0] eng_rdata;

    modport master (
        output disp_valid, disp_addr,
        output ld_valid, ld_we, ld_addr, ld_wdata,
        output eng_valid, eng_we, eng_addr, eng_wdata,
        input  disp_ready, disp_rvalid, disp_rdata,
        input  ld_ready, ld_rvalid, ld_rdata,
        input  eng_ready, eng_rvalid, eng_rdata
    );

    modport slave (
        input  disp_valid, disp_addr,
        input  ld_valid, ld_we, ld_addr, ld_wdata,
        input  eng_valid, eng_we, eng_addr, eng_wdata,
        output disp_ready, disp_rvalid, disp_rdata,
        output ld_ready, ld_rvalid, ld_rdata,
        output eng_ready, eng_rvalid, eng_rdata
    );

endinterface
`default_nettype wire

// File: rtl/frame_ram_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// frame_ram_rd_tag_pipe
// Shift register of requester tags aligning read returns with ram_q.
// Revision: 1.0 - initial release
// ============================================================================
module frame_ram_rd_tag_pipe
    import frame_ram_pkg::*;
#(
    parameter int DEPTH = 1 + c_RD_LATENCY
)(
    input  wire logic     clk_spi,
    input  wire logic     reset,
    input  req_tag_e      i_tag,
    output req_tag_e      o_tag
);

    req_tag_e r_stage [DEPTH];

    always_ff @(posedge clk_spi or posedge reset) begin : shift
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= REQ_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/frame_ram_arbiter.sv
`default_nettype none
// ============================================================================
// frame_ram_arbiter
// Single-port frame RAM arbiter: display first, loader/engine in bursts.
// Revision: 1.0 - initial release
// ============================================================================
module frame_ram_arbiter
    import frame_ram_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int RD_LATENCY = c_RD_LATENCY,
    parameter int BURST_MAX  = 16
)(
    input  wire logic              clk_spi,
    input  wire logic              reset,
    frame_ram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0]      ram_address,
    output logic [DATA_W-1:0]      ram_data,
    output logic                   ram_rden,
    output logic                   ram_wren,
    input  wire logic [DATA_W-1:0] ram_q
);

    localparam logic [7:0] c_burst_max  = 8'(BURST_MAX);
    localparam int         c_pipe_depth = 1 + RD_LATENCY;

    owner_e            r_owner;
    owner_e            w_owner_next;
    logic [7:0]        r_burst_cnt;
    logic [7:0]        w_burst_cnt_next;

    req_tag_e          w_grant;
    req_tag_e          w_owner_tag;
    req_tag_e          w_other_tag;
    req_tag_e          w_tag_in;
    req_tag_e          w_tag_out;
    logic              w_owner_valid;
    logic              w_other_valid;

    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_rden;
    logic              r_ram_wren;

    logic              r_disp_rvalid;
    logic              r_ld_rvalid;
    logic              r_eng_rvalid;
    logic [DATA_W-1:0] r_disp_rdata;
    logic [DATA_W-1:0] r_ld_rdata;
    logic [DATA_W-1:0] r_eng_rdata;

    always_comb begin : arbitrate
        w_owner_tag   = REQ_ENG;
        w_other_tag   = REQ_LD;
        w_owner_valid = bus.eng_valid;
        w_other_valid = bus.ld_valid;
        if (r_owner == OWN_LD) begin
            w_owner_tag   = REQ_LD;
            w_other_tag   = REQ_ENG;
            w_owner_valid = bus.ld_valid;
            w_other_valid = bus.eng_valid;
        end

        // A zero count means no burst is running yet, so the owner holds no
        // claim and the loader takes the first tie after reset.
        w_grant = REQ_NONE;
        if (bus.disp_valid) begin
            w_grant = REQ_DISP;
        end else if (w_owner_valid && (r_burst_cnt != 8'd0) && (r_burst_cnt < c_burst_max)) begin
            w_grant = w_owner_tag;
        end else if (w_other_valid) begin
            w_grant = w_other_tag;
        end else if (w_owner_valid) begin
            w_grant = w_owner_tag;
        end
    end

    always_comb begin : burst_next
        w_owner_next     = r_owner;
        w_burst_cnt_next = r_burst_cnt;
        if ((w_grant == REQ_LD) || (w_grant == REQ_ENG)) begin
            if (w_grant == w_owner_tag) begin
                if (r_burst_cnt < c_burst_max) begin
                    w_burst_cnt_next = r_burst_cnt + 8'd1;
                end
            end else begin
                w_burst_cnt_next = 8'd1;
                if (w_grant == REQ_LD) begin
                    w_owner_next = OWN_LD;
                end else begin
                    w_owner_next = OWN_ENG;
                end
            end
        end
    end

    always_comb begin : select
        w_sel_addr  = bus.disp_addr;
        w_sel_we    = 1'b0;
        w_sel_wdata = r_ram_data;
        case (w_grant)
            REQ_LD: begin
                w_sel_addr  = bus.ld_addr;
                w_sel_we    = bus.ld_we;
                w_sel_wdata = bus.ld_wdata;
            end
            REQ_ENG: begin
                w_sel_addr  = bus.eng_addr;
                w_sel_we    = bus.eng_we;
                w_sel_wdata = bus.eng_wdata;
            end
            default: begin
            end
        endcase

        w_tag_in = REQ_NONE;
        if ((w_grant != REQ_NONE) && !w_sel_we) begin
            w_tag_in = w_grant;
        end
    end

    assign bus.disp_ready = !reset && (w_grant == REQ_DISP);
    assign bus.ld_ready   = !reset && (w_grant == REQ_LD);
    assign bus.eng_ready  = !reset && (w_grant == REQ_ENG);

    always_ff @(posedge clk_spi or posedge reset) begin : state_reg
        if (reset) begin
            r_owner     <= OWN_ENG;
            r_burst_cnt <= 8'd0;
        end else begin
            r_owner     <= w_owner_next;
            r_burst_cnt <= w_burst_cnt_next;
        end
    end

    always_ff @(posedge clk_spi or posedge reset) begin : ram_drive
        if (reset) begin
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_rden    <= 1'b0;
            r_ram_wren    <= 1'b0;
        end else begin
            r_ram_rden <= 1'b0;
            r_ram_wren <= 1'b0;
            if (w_grant != REQ_NONE) begin
                r_ram_address <= w_sel_addr;
                r_ram_data    <= w_sel_wdata;
                r_ram_rden    <= !w_sel_we;
                r_ram_wren    <= w_sel_we;
            end
        end
    end

    frame_ram_rd_tag_pipe #(
        .DEPTH (c_pipe_depth)
    ) u_tag_pipe (
        .clk_spi (clk_spi),
        .reset   (reset),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    always_ff @(posedge clk_spi or posedge reset) begin : return_steer
        if (reset) begin
            r_disp_rvalid <= 1'b0;
            r_ld_rvalid   <= 1'b0;
            r_eng_rvalid  <= 1'b0;
            r_disp_rdata  <= '0;
            r_ld_rdata    <= '0;
            r_eng_rdata   <= '0;
        end else begin
            r_disp_rvalid <= (w_tag_out == REQ_DISP);
            r_ld_rvalid   <= (w_tag_out == REQ_LD);
            r_eng_rvalid  <= (w_tag_out == REQ_ENG);
            if (w_tag_out == REQ_DISP) r_disp_rdata <= ram_q;
            if (w_tag_out == REQ_LD)   r_ld_rdata   <= ram_q;
            if (w_tag_out == REQ_ENG)  r_eng_rdata  <= ram_q;
        end
    end

    assign ram_address     = r_ram_address;
    assign ram_data        = r_ram_data;
    assign ram_rden        = r_ram_rden;
    assign ram_wren        = r_ram_wren;
    assign bus.disp_rvalid = r_disp_rvalid;
    assign bus.ld_rvalid   = r_ld_rvalid;
    assign bus.eng_rvalid  = r_eng_rvalid;
    assign bus.disp_rdata  = r_disp_rdata;
    assign bus.ld_rdata    = r_ld_rdata;
    assign bus.eng_rdata   = r_eng_rdata;

endmodule
`default_nettype wire

// File: tb/tb_frame_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_frame_ram_arbiter
// Directed bench with a per-cycle arbitration/return model and a RAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_frame_ram_arbiter;
    import frame_ram_pkg::*;

    localparam int ADDR_W     = 24;
    localparam int DATA_W     = 1;
    localparam int RD_LATENCY = 2;
    localparam int BURST_MAX  = 16;
    localparam int PIPE_LAT   = 2 + RD_LATENCY;
    localparam int W_DISP     = 0;
    localparam int W_LD       = 1;
    localparam int W_ENG      = 2;

    logic clk_spi = 1'b0;
    logic reset   = 1'b0;
    always #5 clk_spi = ~clk_spi;

    frame_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_rden;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q  = '0;
    logic [DATA_W-1:0] ram_q1 = '0;

    frame_ram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY),
        .BURST_MAX  (BURST_MAX)
    ) dut (
        .clk_spi     (clk_spi),
        .reset       (reset),
        .bus         (bus),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_rden    (ram_rden),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    // RAM macro: samples on the edge, data valid RD_LATENCY edges later.
    bit tb_mem [logic [ADDR_W-1:0]];
    always @(posedge clk_spi) begin
        if (ram_wren) tb_mem[ram_address] = ram_data[0];
        if (ram_rden) ram_q1 <= tb_mem.exists(ram_address) ? tb_mem[ram_address] : 1'b0;
        ram_q <= ram_q1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h at time %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int who;
        bit data;
    } ret_t;

    ret_t              retq[$];
    bit                m_mem [logic [ADDR_W-1:0]];
    int                m_owner = W_ENG;
    int                m_run   = 0;
    int                cyc     = 0;
    bit                exp_rden = 0, exp_wren = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    bit                exp_data = 0;

    function automatic int model_grant();
        bit own_v, oth_v;
        int other;
        if (bus.disp_valid) return W_DISP;
        other = (m_owner == W_LD) ? W_ENG : W_LD;
        own_v = (m_owner == W_LD) ? bus.ld_valid : bus.eng_valid;
        oth_v = (m_owner == W_LD) ? bus.eng_valid : bus.ld_valid;
        if (own_v && m_run > 0 && m_run < BURST_MAX) return m_owner;
        if (oth_v) return other;
        if (own_v) return m_owner;
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int who);
        case (who)
            W_DISP:  return 3'b100;
            W_LD:    return 3'b010;
            W_ENG:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    int                who;
    logic [2:0]        exp_rv;
    ret_t              e;
    logic [ADDR_W-1:0] a;
    bit                we, wd, rd;

    always @(negedge clk_spi) begin : compare
        cyc++;
        if (reset) begin
            check("rst_ready", 32'({bus.disp_ready, bus.ld_ready, bus.eng_ready}), 32'd0);
            check("rst_rvalid", 32'({bus.disp_rvalid, bus.ld_rvalid, bus.eng_rvalid}), 32'd0);
            check("rst_rdata", 32'({bus.disp_rdata, bus.ld_rdata, bus.eng_rdata}), 32'd0);
            check("rst_ram", 32'({ram_rden, ram_wren, ram_data, ram_address}), 32'd0);
            m_owner = W_ENG; m_run = 0; retq.delete();
            exp_rden = 0; exp_wren = 0; exp_addr = '0; exp_data = 0;
        end else begin
            check("ram_en", 32'({ram_rden, ram_wren}), 32'({exp_rden, exp_wren}));
            if (exp_rden || exp_wren) check("ram_address", 32'(ram_address), 32'(exp_addr));
            if (exp_wren) check("ram_data", 32'(ram_data), 32'(exp_data));

            exp_rv = 3'b000;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                e = retq.pop_front();
                exp_rv = onehot(e.who);
            end
            check("rvalid", 32'({bus.disp_rvalid, bus.ld_rvalid, bus.eng_rvalid}), 32'(exp_rv));
            if (exp_rv != 3'b000) begin
                case (e.who)
                    W_DISP:  check("disp_rdata", 32'(bus.disp_rdata), 32'(e.data));
                    W_LD:    check("ld_rdata", 32'(bus.ld_rdata), 32'(e.data));
                    default: check("eng_rdata", 32'(bus.eng_rdata), 32'(e.data));
                endcase
            end

            who = model_grant();
            check("ready", 32'({bus.disp_ready, bus.ld_ready, bus.eng_ready}), 32'(onehot(who)));
            exp_rden = 0; exp_wren = 0;
            if (who >= 0) begin
                wd = exp_data;
                if (who == W_DISP) begin
                    a = bus.disp_addr; we = 0;
                end else if (who == W_LD) begin
                    a = bus.ld_addr; we = bus.ld_we; wd = bus.ld_wdata[0];
                end else begin
                    a = bus.eng_addr; we = bus.eng_we; wd = bus.eng_wdata[0];
                end
                if (we) m_mem[a] = wd;
                else begin
                    rd = m_mem.exists(a) ? m_mem[a] : 1'b0;
                    retq.push_back('{due: cyc + PIPE_LAT, who: who, data: rd});
                end
                exp_rden = !we; exp_wren = we; exp_addr = a; exp_data = wd;
                if (who != W_DISP) begin
                    if (who == m_owner) begin
                        if (m_run < BURST_MAX) m_run++;
                    end else begin
                        m_owner = who; m_run = 1;
                    end
                end
            end
        end
    end

    // ---------------- activity monitors ----------------
    int mon_rden = 0, mon_wren = 0, mon_rv = 0, mon_disp_rv = 0;
    always @(negedge clk_spi) begin
        if (ram_rden) mon_rden++;
        if (ram_wren) mon_wren++;
        if (bus.disp_rvalid || bus.ld_rvalid || bus.eng_rvalid) mon_rv++;
        if (bus.disp_rvalid) mon_disp_rv++;
    end

    task automatic clear_mon();
        mon_rden = 0; mon_wren = 0; mon_rv = 0; mon_disp_rv = 0;
    endtask

    task automatic idle_inputs();
        bus.disp_valid = 0; bus.ld_valid = 0; bus.eng_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_spi); #1;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk_spi);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int seq [64];
    int n_ld, n_eng, n_bad, n_dreq, n_dacc, eng_at, lat, got, val, n_ldrv;
    bit acc_ld, acc_eng;

    initial begin
        bus.disp_valid = 0; bus.disp_addr = '0;
        bus.ld_valid = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.eng_valid = 0; bus.eng_we = 0; bus.eng_addr = '0; bus.eng_wdata = '0;
        tb_mem[24'h000123] = 1'b1;
        m_mem[24'h000123]  = 1'b1;

        // Single display read
        do_reset();
        bus.disp_valid = 1; bus.disp_addr = 24'h000123;
        @(negedge clk_spi);
        check("t1_ready", 32'(bus.disp_ready), 32'd1);
        @(posedge clk_spi); #1;
        bus.disp_valid = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_spi);
            if (k == 1) check("t1_ram", 32'({ram_rden, ram_address}), 32'h0100_0123);
            if (bus.disp_rvalid && lat == 0) begin
                lat = k;
                check("t1_rdata", 32'(bus.disp_rdata), 32'd1);
            end
        end
        check("t1_latency", 32'(lat), 32'd4);

        // Burst fairness
        do_reset();
        bus.ld_valid = 1; bus.ld_we = 1; bus.ld_addr = 24'h001000; bus.ld_wdata = 1'b0;
        bus.eng_valid = 1; bus.eng_we = 0; bus.eng_addr = 24'h001000;
        n_ld = 0; n_eng = 0; n_bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_spi);
            acc_ld = bus.ld_ready; acc_eng = bus.eng_ready;
            seq[i] = acc_ld ? W_LD : (acc_eng ? W_ENG : -1);
            if (seq[i] != (((i / 16) % 2 == 0) ? W_LD : W_ENG)) n_bad++;
            @(posedge clk_spi); #1;
            if (acc_ld) begin
                n_ld++;
                bus.ld_addr = 24'h001000 + 24'(n_ld);
                bus.ld_wdata = 1'(n_ld);
            end
            if (acc_eng) begin
                n_eng++;
                bus.eng_addr = 24'h001000 + 24'(n_eng);
            end
        end
        idle_inputs();
        check("t2_first_loader", 32'(seq[0]), 32'(W_LD));
        check("t2_ld_count", 32'(n_ld), 32'd32);
        check("t2_eng_count", 32'(n_eng), 32'd32);
        check("t2_run_pattern_errors", 32'(n_bad), 32'd0);
        repeat (6) @(posedge clk_spi);
        #1;

        // Display preemption inside a loader burst
        do_reset();
        bus.ld_valid = 1; bus.ld_we = 1; bus.ld_addr = 24'h002000; bus.ld_wdata = 1'b1;
        bus.eng_valid = 1; bus.eng_we = 0; bus.eng_addr = 24'h000123;
        bus.disp_addr = 24'h002000;
        n_ld = 0; n_dreq = 0; n_dacc = 0; eng_at = -1;
        for (int i = 0; i < 60 && eng_at < 0; i++) begin
            bus.disp_valid = (i % 4 == 1);
            @(negedge clk_spi);
            acc_ld = bus.ld_ready;
            if (bus.disp_valid) begin
                n_dreq++;
                if (bus.disp_ready) n_dacc++;
            end
            if (bus.eng_ready) eng_at = i;
            @(posedge clk_spi); #1;
            if (acc_ld) begin
                n_ld++;
                bus.ld_addr = 24'h002000 + 24'(n_ld);
            end
        end
        idle_inputs();
        check("t3_ld_run", 32'(n_ld), 32'd16);
        check("t3_disp_accepted", 32'(n_dacc), 32'd6);
        check("t3_disp_requests", 32'(n_dreq), 32'd6);
        check("t3_first_eng_cycle", 32'(eng_at), 32'd22);
        repeat (6) @(posedge clk_spi);
        #1;

        // Write then read of the same cell
        do_reset();
        bus.ld_valid = 1; bus.ld_we = 1; bus.ld_addr = 24'h0004B0; bus.ld_wdata = 1'b1;
        @(negedge clk_spi);
        check("t4_ld_ready", 32'(bus.ld_ready), 32'd1);
        @(posedge clk_spi); #1;
        bus.ld_valid = 0;
        bus.eng_valid = 1; bus.eng_we = 0; bus.eng_addr = 24'h0004B0;
        @(negedge clk_spi);
        check("t4_eng_ready", 32'(bus.eng_ready), 32'd1);
        @(posedge clk_spi); #1;
        bus.eng_valid = 0;
        got = 0; val = 0; n_ldrv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_spi);
            if (bus.ld_rvalid) n_ldrv++;
            if (bus.eng_rvalid) begin got++; val = int'(bus.eng_rdata); end
        end
        check("t4_eng_rvalid_count", 32'(got), 32'd1);
        check("t4_eng_rdata", 32'(val), 32'd1);
        check("t4_ld_rvalid_count", 32'(n_ldrv), 32'd0);

        // Reset during an in-flight read
        do_reset();
        clear_mon();
        bus.disp_valid = 1; bus.disp_addr = 24'h000123;
        @(posedge clk_spi); #1;
        bus.disp_valid = 0;
        repeat (2) @(posedge clk_spi);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk_spi);
        #1;
        reset = 1'b0;
        @(negedge clk_spi);
        check("t5_release_outputs",
              32'({bus.disp_ready, bus.ld_ready, bus.eng_ready,
                   bus.disp_rvalid, bus.ld_rvalid, bus.eng_rvalid,
                   bus.disp_rdata, bus.ld_rdata, bus.eng_rdata,
                   ram_rden, ram_wren, ram_data}), 32'd0);
        check("t5_release_addr", 32'(ram_address), 32'd0);
        @(posedge clk_spi); #1;
        bus.ld_valid = 1; bus.ld_we = 0; bus.ld_addr = 24'h000010;
        bus.eng_valid = 1; bus.eng_we = 0; bus.eng_addr = 24'h000020;
        @(negedge clk_spi);
        check("t5_first_tie", 32'({bus.ld_ready, bus.eng_ready}), 32'h2);
        @(posedge clk_spi); #1;
        idle_inputs();
        repeat (6) @(posedge clk_spi);
        #1;
        check("t5_no_disp_rvalid", 32'(mon_disp_rv), 32'd0);

        // Idle
        do_reset();
        clear_mon();
        repeat (20) @(posedge clk_spi);
        #1;
        check("t6_idle_rden", 32'(mon_rden), 32'd0);
        check("t6_idle_wren", 32'(mon_wren), 32'd0);
        check("t6_idle_rvalid", 32'(mon_rv), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
